mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, which sets the memory word-address width.
REQ-003 The block SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 The block SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port if_req  input  1  fetch-port request, held until granted.
REQ-006 The block SHALL have port if_addr  input  ADDR_WIDTH  fetch address.
REQ-007 The block SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port if_rdata  output  DATA_WIDTH  fetched word.
REQ-009 The block SHALL have port if_valid  output  1  if_rdata valid, one-cycle pulse.
REQ-010 The block SHALL have port d_req  input  1  data-port request, held until granted.
REQ-011 The block SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 The block SHALL have port d_addr  input  ADDR_WIDTH  data address.
REQ-013 The block SHALL have port d_wdata  input  DATA_WIDTH  store data.
REQ-014 The block SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-015 The block SHALL have port d_rdata  output  DATA_WIDTH  load result.
REQ-016 The block SHALL have port d_valid  output  1  load data or store completion, one-cycle pulse.
REQ-017 The block SHALL have port mem_addr  output  ADDR_WIDTH  address to the single-port RAM.
REQ-018 The block SHALL have port mem_we  output  1  write enable to the RAM.
REQ-019 The block SHALL have port mem_data  output  DATA_WIDTH  write data to the RAM.
REQ-020 The block SHALL have port mem_q  input  DATA_WIDTH  RAM read data, valid the cycle after the address-capture edge.
REQ-021 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have three states: IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on any granted request, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-023 In IDLE, the block SHALL assert exactly one gnt combinationally for the winning requester, and no gnt in any other state.
REQ-024 On the edge where a gnt is high, the block SHALL latch the winner id, address, we and wdata.
REQ-025 In ISSUE, the block SHALL drive mem_addr, mem_data and mem_we (store only) from the latched values; mem_we SHALL be high for exactly that one cycle.
REQ-026 In RESP, the block SHALL pulse the winner's valid for one cycle and drive its rdata from mem_q; rdata SHALL hold its last value otherwise.
REQ-027 The block SHALL complete a store with d_valid in RESP, with d_rdata unchanged.
REQ-028 Latency SHALL be: gnt at edge N, valid high in the cycle after edge N+2; throughput SHALL be one access per 3 cycles.
REQ-029 When both ports request with ARB_RR_EN undefined, the data port SHALL win (fixed priority).
REQ-030 The block SHALL ignore a request arriving while busy until IDLE; a requester keeps its req high until it sees gnt.
REQ-031 Outside ISSUE, mem_addr SHALL hold its last value and mem_we SHALL be 0.

Reset
REQ-032 Asserting clear at any time SHALL force IDLE, mem_we=0, if_valid=0, d_valid=0, busy=0, mem_addr=0, rdata outputs=0, and last-grant=data.
REQ-033 When reset occurs mid-access (ISSUE or RESP), the in-flight access SHALL be dropped with no valid pulse; requesters re-request.

Configuration
REQ-034 With macro ARB_RR_EN defined, the block SHALL resolve conflicts round-robin: the port not granted last wins, and last-grant SHALL update on every gnt.
REQ-035 With ARB_RR_EN undefined, the block SHALL omit the last-grant register and use the fixed data-first priority of REQ-029.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x004 from reset -> if_gnt in cycle 1, mem_addr=0x004 in ISSUE, if_valid one cycle later with if_rdata=RAM[4].
REQ-037 Store then load: store d_addr=0x010, d_wdata=0xDEADBEEF, then load 0x010 -> mem_we high exactly one cycle, then d_rdata=0xDEADBEEF with d_valid.
REQ-038 Conflict: if_req and d_req both high in IDLE -> d_gnt first; if_gnt 3 cycles later (fixed), or alternating grants over 4 conflicts (ARB_RR_EN).
REQ-039 Busy hold-off: d_req raised during ISSUE -> no d_gnt until the next IDLE cycle; busy=1 during ISSUE and RESP.
REQ-040 Reset mid-op: clear pulsed during ISSUE of a store -> mem_we=0 immediately, no d_valid, FSM in IDLE, RAM unchanged if clear precedes the capture edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-port synchronous RAM. A fetch port
// (read-only) and a data port (load/store) compete for the RAM; one access is
// in flight at a time and takes three cycles (IDLE -> ISSUE -> RESP).
//
// Optional build macro:
//   ARB_RR_EN  - round-robin conflict resolution using a last-grant register.
//                When undefined the data port always wins a conflict.
//
// Ports:
//   clock      - single clock, all state updates on posedge
//   clear      - asynchronous active-high reset
//   if_req     - fetch request, held until if_gnt
//   if_addr    - fetch word address
//   if_gnt     - fetch request accepted this cycle (combinational, IDLE only)
//   if_rdata   - fetched word, holds last value between responses
//   if_valid   - one-cycle pulse marking if_rdata valid
//   d_req      - data request, held until d_gnt
//   d_we       - 1 = store, 0 = load
//   d_addr     - data word address
//   d_wdata    - store data
//   d_gnt      - data request accepted this cycle (combinational, IDLE only)
//   d_rdata    - load result, holds last value (stores leave it unchanged)
//   d_valid    - one-cycle pulse: load data valid or store completed
//   mem_addr   - RAM address, driven in ISSUE and held otherwise
//   mem_we     - RAM write enable, high only during ISSUE of a store
//   mem_data   - RAM write data
//   mem_q      - RAM read data, valid the cycle after the address-capture edge
//   busy       - high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;

    // Winner id and access kind captured at the grant edge; the address and
    // write data are captured directly into mem_addr / mem_data.
    logic lat_is_d;
    logic lat_we;

    // High when the data port takes a conflict.
    logic d_priority;

`ifdef ARB_RR_EN
    // 1 = data port was granted most recently. Reset to data so the fetch
    // port wins the first conflict after reset.
    logic last_d;
    assign d_priority = ~last_d;
`else
    assign d_priority = 1'b1;
`endif

    // Grants are only ever issued from IDLE; requests arriving while busy
    // simply wait (requesters hold req until they see gnt).
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state == IDLE) begin
            if (d_req && (!if_req || d_priority)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            busy     <= 1'b0;
            lat_is_d <= 1'b0;
            lat_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
`ifdef ARB_RR_EN
            last_d   <= 1'b1;
`endif
        end else begin
            // Pulses default low; each is raised for exactly one cycle below.
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        lat_is_d <= 1'b1;
                        lat_we   <= d_we;
                        mem_addr <= d_addr;
                        mem_data <= d_wdata;
                        mem_we   <= d_we;
`ifdef ARB_RR_EN
                        last_d   <= 1'b1;
`endif
                    end else if (if_gnt) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        lat_is_d <= 1'b0;
                        lat_we   <= 1'b0;
                        mem_addr <= if_addr;
`ifdef ARB_RR_EN
                        last_d   <= 1'b0;
`endif
                    end
                end

                // The RAM captures mem_addr (and the write) at the edge that
                // leaves ISSUE; its read data is then valid throughout RESP.
                ISSUE: begin
                    state <= RESP;
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (lat_is_d) begin
                        d_valid <= 1'b1;
                        if (!lat_we) begin
                            d_rdata <= mem_q;
                        end
                    end else begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_q;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
